// File: rtl/bus_drive_arbiter_if.sv
// Bus-side signal bundle for bus_drive_arbiter: source requests, tri-state
// output enables, the resolved bus value and the registered consumer word.
interface bus_drive_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int SRC_W  = 2,
  parameter int DATA_W = 16
);
  logic [N_SRC-1:0]  req;
  logic [N_SRC-1:0]  en;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [SRC_W-1:0]  rx_src;
  logic              busy;

  // Arbiter side: owns the enables and the captured word.
  modport master (
    input  req, bus,
    output en, rx_data, rx_valid, rx_src, busy
  );

  // Source/consumer side.
  modport slave (
    output req, bus,
    input  en, rx_data, rx_valid, rx_src, busy
  );
endinterface

// File: rtl/bus_drive_arbiter.sv
// Round-robin owner of the shared tri-state data bus: one-hot output enables
// with a dead turnaround cycle between owners, plus a registered bus sampler.
module bus_drive_arbiter #(
  parameter int N_SRC     = 4,
  parameter int SRC_W     = 2,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_drive_arbiter_if.master  bif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [N_SRC-1:0]  r_en, w_en_nxt;
  logic [SRC_W-1:0]  r_ptr, w_ptr_nxt;
  logic [3:0]        r_count, w_count_nxt;
  logic [SRC_W-1:0]  w_win, w_idx;
  logic              w_any;
  logic              w_capture;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic [SRC_W-1:0]  r_rx_src;

  // Scan from the farthest candidate to the nearest so the nearest requester
  // after the pointer wins; the current owner (at the pointer) ranks last.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = N_SRC; k >= 1; k--) begin
      w_idx = SRC_W'((int'(r_ptr) + k) % N_SRC);
      if (bif.req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = '0;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE, TURN: begin
        if (w_any) begin
          w_state_nxt = DRIVE;
          w_en_nxt    = N_SRC'(1) << w_win;
          w_ptr_nxt   = w_win;
          w_count_nxt = 4'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE: begin
        w_capture = 1'b1;
        if (bif.req[r_ptr] && (r_count < 4'(MAX_BURST))) begin
          w_en_nxt    = r_en;
          w_count_nxt = r_count + 4'd1;
        end else begin
          // Drop the enable for one dead cycle before anyone drives again.
          w_state_nxt = TURN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_en       <= '0;
      r_ptr      <= SRC_W'(N_SRC - 1);
      r_count    <= 4'd0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_src   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_en       <= w_en_nxt;
      r_ptr      <= w_ptr_nxt;
      r_count    <= w_count_nxt;
      r_rx_valid <= w_capture;
      if (w_capture) begin
        r_rx_data <= bif.bus;
        r_rx_src  <= r_ptr;
      end
    end
  end

  assign bif.en       = r_en;
  assign bif.rx_data  = r_rx_data;
  assign bif.rx_valid = r_rx_valid;
  assign bif.rx_src   = r_rx_src;
  assign bif.busy     = (r_state != IDLE);

endmodule
